dmem_arbiter: RTL and testbench

- Two-requester access controller in front of the single-port data_memory (8-bit address, 16-bit data, combinational read, posedge-clk write).
- Port A is the core load/store stage; port B is a secondary master (DMA/debug loader).
- Serialises requests, picks a winner (round-robin or fixed priority), and drives the memory for exactly one cycle per access.
- Returns registered read data with a one-cycle ack pulse per request.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-input picker: single requester wins, ties go by
// fixed priority (A) or to the port opposite the last grant.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    input  logic fixed_prio,
    output logic grant_id
);

    always_comb begin
        grant_id = PORT_A;
        if (req_a && !req_b) begin
            grant_id = PORT_A;
        end else if (req_b && !req_a) begin
            grant_id = PORT_B;
        end else if (req_a && req_b) begin
            grant_id = fixed_prio ? PORT_A : ~last_grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises port A / port B accesses onto the single-port data memory.
// state  | meaning
// IDLE   | waiting; grants and latches a request when one is present
// ACCESS | memory strobed for exactly one cycle from the latched fields
// DONE   | winner's ack high for this cycle, then back to IDLE
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic FIXED_PRIO_L = (FIXED_PRIO != 0);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              grant_id;

    rr_arb2 u_rr_arb2 (
        .req_a      (a_req),
        .req_b      (b_req),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO_L),
        .grant_id   (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d      = ACCESS;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    if (grant_id == PORT_A) begin
                        we_d    = a_we;
                        addr_d  = a_addr;
                        wdata_d = a_wdata;
                    end else begin
                        we_d    = b_we;
                        addr_d  = b_addr;
                        wdata_d = b_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (id_q == PORT_A) begin
                    a_ack_d = 1'b1;
                    if (!we_q) a_rdata_d = mem_rdata;
                end else begin
                    b_ack_d = 1'b1;
                    if (!we_q) b_rdata_d = mem_rdata;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_B;
            id_q         <= PORT_A;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // Memory strobes decode only flops, so they cannot glitch and vanish with reset.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ACCESS) begin
            mem_rd_en = ~we_q;
            mem_wr_en = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    assign busy    = (state_q != IDLE);
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors, arbitration patterns, reset abort,
// and randomized two-port traffic against a memory/fairness reference model.
module tb_dmem_arbiter;

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [7:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;

    logic        a_ack, b_ack, mem_rd_en, mem_wr_en, busy;
    logic [15:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    logic        fp_a_ack, fp_b_ack, fp_rd_en, fp_wr_en, fp_busy;
    logic [15:0] fp_a_rdata, fp_b_rdata, fp_wdata, fp_rdata;
    logic [7:0]  fp_addr;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] ref_mem [256];
    logic        mem_init_done = 1'b0;
    logic        mon_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        if (i == 0) return 16'd2;
        if (i == 1) return 16'd3;
        if (i == 3) return 16'd15;
        return 16'(i * 7 + 1);
    endfunction

    // Behavioural data_memory pair: combinational read, posedge write.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= init_val(i);
                mem1[i] <= init_val(i);
            end
            mem_init_done <= 1'b1;
        end else begin
            if (mem_wr_en) mem0[mem_addr] <= mem_wdata;
            if (fp_wr_en)  mem1[fp_addr]  <= fp_wdata;
        end
    end
    assign mem_rdata = mem0[mem_addr];
    assign fp_rdata  = mem1[fp_addr];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(fp_a_ack), .a_rdata(fp_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(fp_b_ack), .b_rdata(fp_b_rdata),
        .mem_rd_en(fp_rd_en), .mem_wr_en(fp_wr_en), .mem_addr(fp_addr),
        .mem_wdata(fp_wdata), .mem_rdata(fp_rdata), .busy(fp_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input logic p, input logic req, input logic we,
                            input logic [7:0] addr, input logic [15:0] wdata);
        if (p == 1'b0) begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_port(1'b0, 0, 0, 8'h00, 16'h0);
        set_port(1'b1, 0, 0, 8'h00, 16'h0);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {a_ack, b_ack}, 0);
        chk("rst_mem_en", {mem_rd_en, mem_wr_en}, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Single uncontended access, checked cycle by cycle (cycle 0 = request edge).
    task automatic do_single(input vec_t v);
        logic [15:0] exp_wd;
        exp_wd = v.we ? v.wdata : 16'h0;
        set_port(v.port, 1, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk("c1_rd_en", mem_rd_en, !v.we);
        chk("c1_wr_en", mem_wr_en, v.we);
        chk("c1_addr", mem_addr, v.addr);
        chk("c1_wdata", mem_wdata, exp_wd);
        chk("c1_busy", busy, 1);
        chk("c1_acks", {a_ack, b_ack}, 0);
        @(negedge clk);
        chk("c2_acks", {a_ack, b_ack}, v.port ? 2'b01 : 2'b10);
        chk("c2_mem_en", {mem_rd_en, mem_wr_en}, 0);
        chk("c2_rdata", v.port ? b_rdata : a_rdata, v.exp_rdata);
        set_port(v.port, 0, 0, 8'h00, 16'h0);
        if (v.we) ref_mem[v.addr] = v.wdata;
        @(negedge clk);
        chk("c3_acks", {a_ack, b_ack}, 0);
        chk("c3_busy", busy, 0);
    endtask

    // Random traffic for one port; A owns 0x00-0x7F, B owns 0x80-0xFF.
    task automatic rand_port(input logic p, input int n);
        logic [15:0] last_rd;
        logic        we, got;
        logic [7:0]  addr;
        logic [15:0] wd;
        int          lat;
        last_rd = 16'h0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            we   = 1'($urandom_range(0, 1));
            addr = {p, 7'($urandom_range(0, 127))};
            wd   = 16'($urandom);
            set_port(p, 1, we, addr, wd);
            lat = 0;
            got = 1'b0;
            while (lat < 30 && !got) begin
                @(negedge clk);
                lat++;
                got = p ? b_ack : a_ack;
            end
            if (!got) begin
                chk("rnd_timeout", 0, 1);
                set_port(p, 0, 0, 8'h00, 16'h0);
                break;
            end
            chk(p ? "rnd_wait_b" : "rnd_wait_a", (lat >= 2 && lat <= 5), 1);
            if (we) begin
                ref_mem[addr] = wd;
                chk(p ? "rnd_hold_b" : "rnd_hold_a", p ? b_rdata : a_rdata, last_rd);
            end else begin
                chk(p ? "rnd_rd_b" : "rnd_rd_a", p ? b_rdata : a_rdata, ref_mem[addr]);
                last_rd = ref_mem[addr];
            end
            set_port(p, 0, 0, 8'h00, 16'h0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_two_acks", a_ack && b_ack, 0);
            chk("mon_rd_wr", mem_rd_en && mem_wr_en, 0);
        end
    end

    initial begin
        vec_t        vecs[7];
        vec_t        v;
        logic [5:0]  am6, bm6;
        logic [11:0] rr_a, rr_b, fp_a, fp_b;

        vecs[0] = '{1'b0, 1'b0, 8'h03, 16'h0000, 16'd15};
        vecs[1] = '{1'b1, 1'b1, 8'h10, 16'h1234, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'd2};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 16'hA5A5, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'hA5A5};
        vecs[6] = '{1'b0, 1'b0, 8'h01, 16'h0000, 16'd3};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 7; i++) do_single(vecs[i]);

        // Simultaneous reads after reset: A first, then B.
        do_reset();
        am6 = '0; bm6 = '0;
        set_port(1'b0, 1, 0, 8'h00, 16'h0);
        set_port(1'b1, 1, 0, 8'h01, 16'h0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            am6[c-1] = a_ack;
            bm6[c-1] = b_ack;
            if (a_ack) set_port(1'b0, 0, 0, 8'h00, 16'h0);
            if (b_ack) set_port(1'b1, 0, 0, 8'h00, 16'h0);
        end
        chk("sim_a_ack_cycles", am6, 6'b000010);
        chk("sim_b_ack_cycles", bm6, 6'b010000);
        chk("sim_a_rdata", a_rdata, 16'd2);
        chk("sim_b_rdata", b_rdata, 16'd3);

        // Continuous dual requests: alternation vs. A-starves-B.
        do_reset();
        rr_a = '0; rr_b = '0; fp_a = '0; fp_b = '0;
        set_port(1'b0, 1, 0, 8'h00, 16'h0);
        set_port(1'b1, 1, 0, 8'h01, 16'h0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            rr_a[c-1] = a_ack;    rr_b[c-1] = b_ack;
            fp_a[c-1] = fp_a_ack; fp_b[c-1] = fp_b_ack;
        end
        chk("rr_a_acks", rr_a, 12'h082);
        chk("rr_b_acks", rr_b, 12'h410);
        chk("fp_a_acks", fp_a, 12'h492);
        chk("fp_b_acks", fp_b, 12'h000);
        chk("fp_a_rdata", fp_a_rdata, 16'd2);

        // Reset during the ACCESS cycle of a write.
        do_reset();
        set_port(1'b0, 1, 1, 8'h20, 16'hBEEF);
        @(negedge clk);
        chk("rw_wr_en_pre", mem_wr_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rw_wr_en_drop", mem_wr_en, 0);
        chk("rw_busy", busy, 0);
        chk("rw_addr", mem_addr, 0);
        set_port(1'b0, 0, 0, 8'h00, 16'h0);
        @(negedge clk);
        chk("rw_ack", {a_ack, b_ack}, 0);
        chk("rw_mem_kept", mem0[8'h20], 16'h00E1);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'h00E1};
        do_single(v);

        // Randomized two-port traffic.
        do_reset();
        fork
            rand_port(1'b0, 40);
            rand_port(1'b1, 40);
        join
        repeat (4) @(negedge clk);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
